// File: rtl/uart_pkg.sv
// Shared constants and types for the BCD record UART receiver.
// Holds the ASCII framing values, error cause codes and bit-FSM states.
package uart_pkg;

    localparam logic [6:0] ASCII_ZERO = 7'h30;
    localparam logic [6:0] ASCII_CR   = 7'h0D;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_PAR  = 2'b01;
    localparam logic [1:0] ERR_STOP = 2'b10;
    localparam logic [1:0] ERR_SEQ  = 2'b11;

    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    function automatic logic is_digit(input logic [6:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_ZERO + 7'd9);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Character deserialiser: 2-flop synchroniser, bit FSM and bit-time counter.
// Emits a one-cycle byte_done at the stop sample with char and frame checks.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 417
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [6:0] ch,
    output logic       byte_done,
    output logic       par_err,
    output logic       stop_err
);

    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             rx;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             done_d;

    assign rx = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                // Leaving at the stop sample lets a start edge in the second half be caught.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign byte_done = done_d;
    assign ch        = shift_q[6:0];
    assign par_err   = ^shift_q;
    assign stop_err  = ~rx;

endmodule

// File: rtl/uart_rx_bcd.sv
// Two-digit BCD record receiver: expects digit1, digit0, CR and presents the
// digits with a valid strobe, or an err strobe with a held cause code.
module uart_rx_bcd
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 417
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code
);

    logic [6:0] ch;
    logic       byte_done;
    logic       par_err;
    logic       stop_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .ch        (ch),
        .byte_done (byte_done),
        .par_err   (par_err),
        .stop_err  (stop_err)
    );

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       shadow1_q, shadow1_d;
    logic [3:0]       shadow0_q, shadow0_d;
    logic [3:0]       bcd1_q, bcd1_d;
    logic [3:0]       bcd0_q, bcd0_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             fail;
    logic [1:0]       cause;

    always_comb begin
        idx_d      = idx_q;
        shadow1_d  = shadow1_q;
        shadow0_d  = shadow0_q;
        bcd1_d     = bcd1_q;
        bcd0_d     = bcd0_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        fail       = 1'b0;
        cause      = ERR_NONE;
        if (byte_done) begin
            if (stop_err) begin
                fail  = 1'b1;
                cause = ERR_STOP;
            end else if (par_err) begin
                fail  = 1'b1;
                cause = ERR_PAR;
            end else begin
                case (idx_q)
                    2'd0, 2'd1: begin
                        if (is_digit(ch)) begin
                            if (idx_q == 2'd0) shadow1_d = ch[3:0];
                            else               shadow0_d = ch[3:0];
                            idx_d = idx_q + 2'd1;
                        end else begin
                            fail  = 1'b1;
                            cause = ERR_SEQ;
                        end
                    end
                    default: begin
                        if (ch == ASCII_CR) begin
                            bcd1_d  = shadow1_q;
                            bcd0_d  = shadow0_q;
                            valid_d = 1'b1;
                            idx_d   = '0;
                        end else begin
                            fail  = 1'b1;
                            cause = ERR_SEQ;
                        end
                    end
                endcase
            end
            // Any rejection restarts the record; stale shadows are overwritten before use.
            if (fail) begin
                err_d      = 1'b1;
                err_code_d = cause;
                idx_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            shadow1_q  <= '0;
            shadow0_q  <= '0;
            bcd1_q     <= '0;
            bcd0_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            idx_q      <= idx_d;
            shadow1_q  <= shadow1_d;
            shadow0_q  <= shadow0_d;
            bcd1_q     <= bcd1_d;
            bcd0_q     <= bcd0_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bcd1     = bcd1_q;
    assign bcd0     = bcd0_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_uart_rx_bcd.sv
// Scoreboard bench for uart_rx_bcd: a record model predicts each valid/err
// strobe when a frame is driven; a monitor pops and compares on every strobe.
module tb_uart_rx_bcd;

    localparam int CPB = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic       valid;
    logic       err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_rx_bcd #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .bcd1     (bcd1),
        .bcd0     (bcd0),
        .valid    (valid),
        .err      (err),
        .err_code (err_code)
    );

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
        logic [3:0] b1;
        logic [3:0] b0;
    } evt_t;

    evt_t exp_q[$];
    evt_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_evt = 0;

    int         m_idx;
    logic [3:0] m_s1, m_s0, m_b1, m_b0;
    logic [1:0] m_code;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_idx  = 0;
        m_s1   = 4'd0;
        m_s0   = 4'd0;
        m_b1   = 4'd0;
        m_b0   = 4'd0;
        m_code = 2'b00;
    endtask

    task automatic model_char(input logic [6:0] d, input logic p, input logic s);
        evt_t       e;
        logic       bad;
        logic [1:0] c;
        bad = 1'b0;
        c   = 2'b00;
        if (!s) begin
            bad = 1'b1; c = 2'b10;
        end else if ((^d) != p) begin
            bad = 1'b1; c = 2'b01;
        end else if (m_idx < 2) begin
            if (d >= 7'h30 && d <= 7'h39) begin
                if (m_idx == 0) m_s1 = d[3:0];
                else            m_s0 = d[3:0];
                m_idx++;
            end else begin
                bad = 1'b1; c = 2'b11;
            end
        end else if (d == 7'h0D) begin
            m_b1     = m_s1;
            m_b0     = m_s0;
            m_idx    = 0;
            e.is_err = 1'b0;
            e.code   = m_code;
            e.b1     = m_b1;
            e.b0     = m_b0;
            exp_q.push_back(e);
        end else begin
            bad = 1'b1; c = 2'b11;
        end
        if (bad) begin
            m_code   = c;
            m_idx    = 0;
            e.is_err = 1'b1;
            e.code   = c;
            e.b1     = m_b1;
            e.b0     = m_b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
        model_char(d, p, s);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rx_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = p;
        repeat (CPB) @(negedge clk);
        rx_in = s;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic send_ok(input logic [6:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (valid || err)) begin
            n_evt++;
            if (valid && err) chk("valid_and_err", 1, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {err, valid}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_kind_err", err, mon_e.is_err);
                chk("err_code", err_code, mon_e.code);
                chk("bcd1", bcd1, mon_e.b1);
                chk("bcd0", bcd0, mon_e.b0);
                $display("event err=%0d code=%0d bcd1=%0d bcd0=%0d", err, err_code, bcd1, bcd0);
            end
        end
    end

    initial begin
        int ev0;
        rst_n = 1'b0;
        rx_in = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_bcd1", bcd1, 0);
        chk("rst_bcd0", bcd0, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        rst_n = 1'b1;
        ev0 = n_evt;
        repeat (50) @(negedge clk);
        chk("idle_strobes", n_evt - ev0, 0);

        // Good record 7,3
        ev0 = n_evt;
        send_ok(7'h37); send_ok(7'h33); send_ok(7'h0D);
        drain();
        chk("rec73_events", n_evt - ev0, 1);
        chk("rec73_bcd1", bcd1, 7);
        chk("rec73_bcd0", bcd0, 3);

        // Parity error, then good record 2,9
        send_frame(7'h37, 1'b0, 1'b1);
        send_ok(7'h32); send_ok(7'h39); send_ok(7'h0D);
        drain();
        chk("rec29_bcd1", bcd1, 2);
        chk("rec29_bcd0", bcd0, 9);

        // Bad stop bit on CR: outputs keep 2,9
        send_ok(7'h35); send_ok(7'h31); send_frame(7'h0D, 1'b1, 1'b0);
        drain();
        chk("stop_bcd1", bcd1, 2);
        chk("stop_bcd0", bcd0, 9);
        chk("stop_code", err_code, 2);

        // ':' as second digit, then good record 4,6
        send_ok(7'h34); send_frame(7'h3A, 1'b0, 1'b1);
        send_ok(7'h34); send_ok(7'h36); send_ok(7'h0D);
        drain();
        chk("rec46_bcd1", bcd1, 4);
        chk("rec46_bcd0", bcd0, 6);

        // 2-clock glitch on idle line
        ev0 = n_evt;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_strobes", n_evt - ev0, 0);

        // Reset in the middle of digit0
        send_ok(7'h38);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("midrst_bcd1", bcd1, 0);
        chk("midrst_bcd0", bcd0, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_code", err_code, 0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_ok(7'h31); send_ok(7'h32); send_ok(7'h0D);
        drain();
        chk("rec12_bcd1", bcd1, 1);
        chk("rec12_bcd0", bcd0, 2);

        chk("leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
